// File: rtl/param_serializer_if.sv
// param_serializer_if
// Handshake and serial-output bundle for param_serializer.
//   master : word producer. Drives load, data_in and send, and observes the status outputs.
//   slave  : the serializer. Samples load, data_in and send, and drives data_out, busy, done,
//            hold_valid and overrun.
interface param_serializer_if #(
   parameter int DATA_W = 12
);
   logic              load;
   logic [DATA_W-1:0] data_in;
   logic              send;
   logic              data_out;
   logic              busy;
   logic              done;
   logic              hold_valid;
   logic              overrun;

   modport master (
      output load, data_in, send,
      input  data_out, busy, done, hold_valid, overrun
   );

   modport slave (
      input  load, data_in, send,
      output data_out, busy, done, hold_valid, overrun
   );
endinterface

// File: rtl/param_serializer.sv
// param_serializer
// Parameterised parallel-to-serial converter. It has a one-entry holding register, so the
// producer can stage the next word while the current frame shifts out. A frame is DATA_W data
// bits, optionally followed by one parity bit. Frames run back-to-back while send stays high and
// a word is held.
// Ports:
//   CLK  : clock. All state updates happen on the rising edge.
//   rst  : asynchronous reset, active high. It aborts any frame in flight.
//   bus  : param_serializer_if.slave.
//          load/data_in/send come in from the producer.
//          data_out/busy/done/hold_valid/overrun go out. All of them are registered.
module param_serializer #(
   parameter int DATA_W     = 12,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input logic               CLK,
   input logic               rst,
   param_serializer_if.slave bus
);

   localparam int             CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2
   } state_t;

   // Parity bit for a word: the XOR of all its bits, inverted when odd parity is selected.
   function automatic logic frame_parity(input logic [DATA_W-1:0] word);
      return (^word) ^ PARITY_ODD;
   endfunction

   // Bit that goes out next. It sits at the leading end of the shift register.
   function automatic logic lead_bit(input logic [DATA_W-1:0] word);
      return MSB_FIRST ? word[DATA_W-1] : word[0];
   endfunction

   // Drop the leading bit so that the following bit becomes the new leading bit.
   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] word);
      return MSB_FIRST ? {word[DATA_W-2:0], 1'b0} : {1'b0, word[DATA_W-1:1]};
   endfunction

   state_t            state_q,      state_d;
   logic [DATA_W-1:0] shift_q,      shift_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              par_q,        par_d;
   logic [DATA_W-1:0] hold_q,       hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic              data_out_q,   data_out_d;
   logic              busy_q,       busy_d;
   logic              done_q,       done_d;
   logic              overrun_q,    overrun_d;

   logic             last_data;
   logic             final_period;
   logic             start_frame;
   logic [CNT_W-1:0] cnt_inc;

   // Frame-boundary decode. A new frame may start from idle or from the last bit period of the
   // current frame; the second case gives back-to-back frames with no gap.
   always_comb begin
      last_data    = (cnt_q == LAST_IDX);
      cnt_inc      = cnt_q + CNT_W'(1);
      final_period = (state_q == ST_PAR) ||
                     ((state_q == ST_SHIFT) && last_data && (PARITY_EN == 1'b0));
      start_frame  = ((state_q == ST_IDLE) || final_period) && bus.send && hold_valid_q;
   end

   // Next-state and output logic for the shift sequencer, plus the holding register.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      par_d        = par_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      data_out_d   = data_out_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      overrun_d    = 1'b0;

      if (start_frame) begin
         // Parity is computed from the whole word here, so the shift path never needs it.
         state_d    = ST_SHIFT;
         shift_d    = advance(hold_q);
         data_out_d = lead_bit(hold_q);
         cnt_d      = {CNT_W{1'b0}};
         par_d      = frame_parity(hold_q);
         busy_d     = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               data_out_d = IDLE_LEVEL;
               busy_d     = 1'b0;
            end
            ST_SHIFT: begin
               if (!last_data) begin
                  data_out_d = lead_bit(shift_q);
                  shift_d    = advance(shift_q);
                  cnt_d      = cnt_inc;
                  done_d     = (cnt_inc == LAST_IDX) && (PARITY_EN == 1'b0);
               end else if (PARITY_EN) begin
                  state_d    = ST_PAR;
                  data_out_d = par_q;
                  done_d     = 1'b1;
               end else begin
                  state_d    = ST_IDLE;
                  data_out_d = IDLE_LEVEL;
                  busy_d     = 1'b0;
               end
            end
            ST_PAR: begin
               state_d    = ST_IDLE;
               data_out_d = IDLE_LEVEL;
               busy_d     = 1'b0;
            end
            default: begin
               state_d    = ST_IDLE;
               data_out_d = IDLE_LEVEL;
               busy_d     = 1'b0;
            end
         endcase
      end

      // A held word that a starting frame consumes on this edge is not lost, so no overrun.
      if (bus.load) begin
         hold_d       = bus.data_in;
         hold_valid_d = 1'b1;
         overrun_d    = hold_valid_q && !start_frame;
      end else begin
         hold_d       = hold_q;
         hold_valid_d = hold_valid_q && !start_frame;
         overrun_d    = 1'b0;
      end
   end

   // State and output registers. The asynchronous reset drops any frame in flight at once.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= {DATA_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         par_q        <= 1'b0;
         hold_q       <= {DATA_W{1'b0}};
         hold_valid_q <= 1'b0;
         data_out_q   <= IDLE_LEVEL;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         par_q        <= par_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         data_out_q   <= data_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.hold_valid = hold_valid_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_param_serializer.sv
// tb_param_serializer
// Runs four serializer configurations side by side on the same stimulus. Each one is compared
// every cycle against a frame-queue reference model. On top of that there are table vectors
// and hand-written corner sequences.
//   cfg0: MSB first, no parity,   idle level 0
//   cfg1: LSB first, no parity,   idle level 0
//   cfg2: MSB first, even parity, idle level 0
//   cfg3: LSB first, odd parity,  idle level 1
module tb_param_serializer;
   localparam int W = 12;
   localparam logic [3:0] CFG_MSB  = 4'b0101;
   localparam logic [3:0] CFG_PAR  = 4'b1100;
   localparam logic [3:0] CFG_ODD  = 4'b1000;
   localparam logic [3:0] CFG_IDLE = 4'b1000;

   logic clk = 1'b1;
   logic rst;
   always #5 clk = ~clk;

   param_serializer_if #(.DATA_W(W)) bus0 ();
   param_serializer_if #(.DATA_W(W)) bus1 ();
   param_serializer_if #(.DATA_W(W)) bus2 ();
   param_serializer_if #(.DATA_W(W)) bus3 ();

   param_serializer #(.DATA_W(W), .MSB_FIRST(CFG_MSB[0]), .PARITY_EN(CFG_PAR[0]),
                      .PARITY_ODD(CFG_ODD[0]), .IDLE_LEVEL(CFG_IDLE[0]))
      u0 (.CLK(clk), .rst(rst), .bus(bus0));
   param_serializer #(.DATA_W(W), .MSB_FIRST(CFG_MSB[1]), .PARITY_EN(CFG_PAR[1]),
                      .PARITY_ODD(CFG_ODD[1]), .IDLE_LEVEL(CFG_IDLE[1]))
      u1 (.CLK(clk), .rst(rst), .bus(bus1));
   param_serializer #(.DATA_W(W), .MSB_FIRST(CFG_MSB[2]), .PARITY_EN(CFG_PAR[2]),
                      .PARITY_ODD(CFG_ODD[2]), .IDLE_LEVEL(CFG_IDLE[2]))
      u2 (.CLK(clk), .rst(rst), .bus(bus2));
   param_serializer #(.DATA_W(W), .MSB_FIRST(CFG_MSB[3]), .PARITY_EN(CFG_PAR[3]),
                      .PARITY_ODD(CFG_ODD[3]), .IDLE_LEVEL(CFG_IDLE[3]))
      u3 (.CLK(clk), .rst(rst), .bus(bus3));

   int n_checks = 0;
   int n_err    = 0;

   // Reference model. Each configuration holds the bit list of its current frame plus a read
   // position. An empty remainder means idle; a remainder of exactly one bit means the last bit
   // period of the frame.
   logic [W-1:0] m_hold [4];
   logic         m_hv   [4];
   logic         m_ov   [4];
   logic [W:0]   m_bits [4];
   int           m_len  [4];
   int           m_pos  [4];

   typedef struct {
      logic         l;
      logic         s;
      logic [W-1:0] d;
      logic         eo;
      logic         eb;
      logic         ed;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_hold[c] = '0;
         m_hv[c]   = 1'b0;
         m_ov[c]   = 1'b0;
         m_bits[c] = '0;
         m_len[c]  = 0;
         m_pos[c]  = 0;
      end
   endtask

   task automatic model_edge(input logic l, input logic [W-1:0] d, input logic s);
      logic st;
      for (int c = 0; c < 4; c++) begin
         if (m_pos[c] < m_len[c]) m_pos[c]++;
         st = (m_pos[c] == m_len[c]) && s && m_hv[c];
         if (st) begin
            for (int i = 0; i < W; i++)
               m_bits[c][i] = CFG_MSB[c] ? m_hold[c][W-1-i] : m_hold[c][i];
            m_bits[c][W] = (^m_hold[c]) ^ CFG_ODD[c];
            m_len[c]     = W + (CFG_PAR[c] ? 1 : 0);
            m_pos[c]     = 0;
         end
         m_ov[c] = l && m_hv[c] && !st;
         m_hv[c] = l || (m_hv[c] && !st);
         if (l) m_hold[c] = d;
      end
   endtask

   // Packed as {data_out, busy, done, hold_valid, overrun}.
   function automatic logic [4:0] dut_out(input int c);
      case (c)
         0:       return {bus0.data_out, bus0.busy, bus0.done, bus0.hold_valid, bus0.overrun};
         1:       return {bus1.data_out, bus1.busy, bus1.done, bus1.hold_valid, bus1.overrun};
         2:       return {bus2.data_out, bus2.busy, bus2.done, bus2.hold_valid, bus2.overrun};
         default: return {bus3.data_out, bus3.busy, bus3.done, bus3.hold_valid, bus3.overrun};
      endcase
   endfunction

   function automatic logic [4:0] model_out(input int c);
      logic busy;
      busy = (m_pos[c] < m_len[c]);
      return {busy ? m_bits[c][m_pos[c]] : CFG_IDLE[c], busy,
              (m_len[c] - m_pos[c]) == 1, m_hv[c], m_ov[c]};
   endfunction

   task automatic compare_all();
      logic [4:0] a;
      logic [4:0] e;
      for (int c = 0; c < 4; c++) begin
         a = dut_out(c);
         e = model_out(c);
         chk($sformatf("cfg%0d data_out", c),   32'(a[4]), 32'(e[4]));
         chk($sformatf("cfg%0d busy", c),       32'(a[3]), 32'(e[3]));
         chk($sformatf("cfg%0d done", c),       32'(a[2]), 32'(e[2]));
         chk($sformatf("cfg%0d hold_valid", c), 32'(a[1]), 32'(e[1]));
         chk($sformatf("cfg%0d overrun", c),    32'(a[0]), 32'(e[0]));
      end
   endtask

   task automatic drive(input logic l, input logic [W-1:0] d, input logic s);
      bus0.load = l; bus0.data_in = d; bus0.send = s;
      bus1.load = l; bus1.data_in = d; bus1.send = s;
      bus2.load = l; bus2.data_in = d; bus2.send = s;
      bus3.load = l; bus3.data_in = d; bus3.send = s;
   endtask

   // One clock: drive the inputs, let the edge happen, advance the model, and check every
   // configuration on the falling edge.
   task automatic step(input logic l, input logic [W-1:0] d, input logic s);
      drive(l, d, s);
      @(posedge clk);
      model_edge(l, d, s);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0);
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] word_a;
      logic [W-1:0] word_b;
      logic [W-1:0] seq_a;
      logic [W-1:0] seq_b_lsb;
      logic [W-1:0] got;
      int           done_at[$];
      int           gap;

      word_a    = 12'b110110110110;
      word_b    = 12'b100100010001;
      seq_a     = 12'b110110110110;   // cfg0 send order, first bit leftmost
      seq_b_lsb = 12'b100010001001;   // cfg1 send order for word_b, first bit leftmost

      // Test 1 as a table: load with send high, 12 data bits, then idle.
      tbl[0] = '{l: 1'b1, s: 1'b1, d: word_a, eo: 1'b0, eb: 1'b0, ed: 1'b0};
      for (int i = 0; i < W; i++)
         tbl[i+1] = '{l: 1'b0, s: 1'b1, d: '0, eo: seq_a[W-1-i], eb: 1'b1, ed: (i == W-1)};
      tbl[13] = '{l: 1'b0, s: 1'b0, d: '0, eo: 1'b0, eb: 1'b0, ed: 1'b0};

      rst = 1'b1;
      drive(1'b0, '0, 1'b0);
      model_reset();
      #14;
      compare_all();
      chk("reset data_out", 32'(bus0.data_out), 32'd0);
      chk("reset idle3",    32'(bus3.data_out), 32'd1);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].l, tbl[i].d, tbl[i].s);
         chk($sformatf("t1[%0d] data_out", i), 32'(bus0.data_out), 32'(tbl[i].eo));
         chk($sformatf("t1[%0d] busy", i),     32'(bus0.busy),     32'(tbl[i].eb));
         chk($sformatf("t1[%0d] done", i),     32'(bus0.done),     32'(tbl[i].ed));
      end
      // cfg2 (even parity): word_a has eight ones, so bit 13 is 0 and done is high on it.
      chk("t3 even parity", 32'(bus2.data_out), 32'd0);
      chk("t3 even done",   32'(bus2.done),     32'd1);
      step(1'b0, '0, 1'b0);
      chk("t3 even idle", 32'(bus2.busy), 32'd0);

      // Test 2: LSB-first order on cfg1. Test 3 (odd parity) is checked on cfg3.
      do_reset();
      step(1'b1, word_b, 1'b1);
      for (int i = 0; i < W; i++) begin
         step(1'b0, word_b, 1'b1);
         chk($sformatf("t2 bit%0d", i), 32'(bus1.data_out), 32'(seq_b_lsb[W-1-i]));
      end
      step(1'b0, word_b, 1'b0);
      chk("t3 odd parity", 32'(bus3.data_out), 32'd1);
      chk("t3 odd done",   32'(bus3.done),     32'd1);

      // Test 4: back-to-back frames, with word_b loaded while word_a is shifting.
      do_reset();
      gap = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         step(cyc == 0 || cyc == 3, (cyc == 0) ? word_a : word_b, 1'b1);
         if (bus0.done) done_at.push_back(cyc);
         if (cyc >= 1 && cyc <= 24 && !bus0.busy) gap++;
         if (cyc == 3)  chk("t4 hold after load", 32'(bus0.hold_valid), 32'd1);
         if (cyc == 13) chk("t4 hold consumed",   32'(bus0.hold_valid), 32'd0);
      end
      chk("t4 done count", 32'(done_at.size()), 32'd2);
      if (done_at.size() == 2) begin
         chk("t4 first done", 32'(done_at[0]), 32'd12);
         chk("t4 done spacing", 32'(done_at[1] - done_at[0]), 32'd12);
      end
      chk("t4 busy gap", 32'(gap), 32'd0);

      // Test 5: overrun, latest word wins, then send with nothing held.
      do_reset();
      step(1'b1, word_a, 1'b0);
      step(1'b1, word_b, 1'b0);
      chk("t5 overrun pulse", 32'(bus0.overrun), 32'd1);
      step(1'b0, '0, 1'b0);
      chk("t5 overrun clear", 32'(bus0.overrun), 32'd0);
      got = '0;
      for (int i = 0; i < W; i++) begin
         step(1'b0, '0, 1'b1);
         got = {got[W-2:0], bus0.data_out};
      end
      chk("t5 sent word", 32'(got), 32'(word_b));
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b1);
         chk("t5 empty busy",     32'(bus0.busy),     32'd0);
         chk("t5 empty data_out", 32'(bus0.data_out), 32'd0);
      end

      // Test 6: reset asserted in the middle of a frame.
      do_reset();
      step(1'b1, word_a, 1'b1);
      for (int i = 0; i < 6; i++) step(i == 2, word_b, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6 async data_out", 32'(bus0.data_out),   32'd0);
      chk("t6 async busy",     32'(bus0.busy),       32'd0);
      chk("t6 async hold",     32'(bus0.hold_valid), 32'd0);
      chk("t6 async done",     32'(bus0.done),       32'd0);
      chk("t6 async idle3",    32'(bus3.data_out),   32'd1);
      model_reset();
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, word_b, 1'b1);
      got = '0;
      for (int i = 0; i < W; i++) begin
         step(1'b0, '0, 1'b1);
         got = {got[W-2:0], bus0.data_out};
      end
      chk("t6 after reset word", 32'(got), 32'(word_b));
      step(1'b0, '0, 1'b0);

      // Randomised traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++)
         step($urandom_range(3) == 0, W'($urandom), $urandom_range(3) != 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised parallel-to-serial converter. Successor to the fixed 12-bit load/send serializer. Adds:
- configurable word width and bit order
- optional parity bit
- one-entry holding register, so the next word can be loaded while the current one shifts
- busy/done/overrun status
Sits between a word-producing block and a single-wire serial output, clocked by CLK.

Parameters:
DATA_W, 12, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit DATA_W-1 sent first; 0 = bit 0 sent first
PARITY_EN, 0, 1 = append one parity bit after each word
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (only used when PARITY_EN=1)
IDLE_LEVEL, 0, value driven on data_out when not transmitting

Ports:
CLK  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  capture data_in into holding register on this edge
data_in  input  DATA_W  parallel word
send  input  1  level enable; transmission runs while high and a word is held
data_out  output  1  registered serial bit
busy  output  1  high while a word (or its parity bit) is on data_out
done  output  1  high during the final bit period of each frame
hold_valid  output  1  holding register occupied
overrun  output  1  one-cycle pulse: load overwrote an unconsumed held word

Behaviour:
- Reset (async, rst=1): state IDLE, data_out=IDLE_LEVEL, busy=0, done=0, hold_valid=0, overrun=0, shift register and counter cleared. Reset mid-frame aborts the frame immediately; no partial done.
- States: IDLE, SHIFT, PAR (PAR exists only if PARITY_EN=1).
- Load:
  - load=1 at an edge writes hold<=data_in, hold_valid<=1.
  - If hold_valid was 1 and the held word is not consumed at that same edge, overrun pulses 1 cycle and the old word is lost (latest wins).
- Start: at an edge where state is IDLE (or the final bit period), send=1 and hold_valid=1:
  - hold moves to shift register; hold_valid clears unless load=1 at the same edge (then hold takes the new data_in, hold_valid stays 1, no overrun).
- Timing relative to start edge k:
  - After edge k: first bit on data_out; busy=1.
  - After edge k+i: bit i, for i = 0..DATA_W-1. Each bit lasts exactly one clock.
  - If PARITY_EN=1: after edge k+DATA_W, the parity bit is on data_out. Parity = XOR of the word, inverted if PARITY_ODD=1.
- done: high exactly during the last bit period of the frame (last data bit, or parity bit if enabled).
- Edge ending the final bit period:
  - If send=1 and hold_valid=1: the next frame starts with no gap (back-to-back), busy stays 1.
  - Otherwise: go to IDLE, data_out=IDLE_LEVEL, busy=0.
- send dropping mid-frame does not abort; the frame completes, then the block idles.
- send=1 with hold_valid=0: remain IDLE; data_out=IDLE_LEVEL.
- Data-bit counter width is $clog2(DATA_W+1); it wraps only via reload at frame start.
- load while busy is legal and does not disturb the frame in flight.
- Frame length is DATA_W+PARITY_EN cycles.

Test Plan:
1. Defaults, rst high 15ns then low, load 12'b110110110110, send held high:
   - data_out after start edge: 1,1,0,1,1,0,1,1,0,1,1,0, one bit per clock
   - done high only on the 12th bit; then busy=0 and data_out=0
2. MSB_FIRST=0, load 12'b100100010001, send high:
   - data_out: 1,0,0,0,1,0,0,0,1,0,0,1
3. PARITY_EN=1:
   - even parity: word 110110110110 (8 ones) gives parity bit 0 as the 13th bit, with done on that bit
   - PARITY_ODD=1: word 100100010001 (4 ones) gives parity bit 1
4. Back-to-back:
   - load A=110110110110, start, then load B=100100010001 mid-frame, send held high
   - B's first bit follows A's last bit with no idle cycle; done pulses twice, 12 cycles apart; hold_valid 1 then 0
5. Overrun and idle cases:
   - send=0; load A, then load B next cycle → overrun pulses once
   - send then transmits B only
   - send=1 with nothing loaded → data_out stays IDLE_LEVEL, busy=0
6. Reset mid-frame:
   - assert rst after bit 5 → data_out=IDLE_LEVEL, busy=0, hold_valid=0 asynchronously (before the next edge), no done
   - after release, a new load/send transmits normally
